// File: rtl/multicycle_cla_adder.sv
// Multicycle adder: one K-bit carry-lookahead slice per clock, N/K cycles per operation.
// Define CLA_ADDER_SUB_EN to enable subtraction through the sub input.
module multicycle_cla_adder #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] num1,
    input  logic [N-1:0] num2,
    input  logic         sub,
    output logic         busy,
    output logic         done,
    output logic [N:0]   result,
    output logic         overflow
);

    localparam int NS    = N / K;
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [N:0]         result_q, result_d;
    logic               overflow_q, overflow_d;

    logic [K-1:0]       sa, sb, sg, sp, ssum;
    logic [K:0]         sc;
    logic               pp, term, last, accept;
    logic [N-1:0]       b_new;
    logic               carry_new;

`ifdef CLA_ADDER_SUB_EN
    always_comb begin
        b_new     = sub ? ~num2 : num2;
        carry_new = sub;
    end
`else
    logic unused_sub;
    always_comb begin
        unused_sub = sub;
        b_new      = num2;
        carry_new  = 1'b0;
    end
`endif

    // Operand slice selected by the current slice index.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int unsigned s = 0; s < NS; s++) begin
            if (idx_q == IDX_W'(s)) begin
                sa = a_q[s*K +: K];
                sb = b_q[s*K +: K];
            end
        end
        last = (idx_q == IDX_W'(NS - 1));
    end

    // Each carry is a flat sum of generate/propagate products, no ripple chain.
    always_comb begin
        sg    = sa & sb;
        sp    = sa ^ sb;
        sc    = '0;
        sc[0] = carry_q;
        pp    = 1'b0;
        term  = 1'b0;
        for (int unsigned j = 1; j <= K; j++) begin
            term = 1'b0;
            for (int unsigned m = 0; m < j; m++) begin
                pp = sg[m];
                for (int unsigned t = m + 1; t < j; t++) begin
                    pp = pp & sp[t];
                end
                term = term | pp;
            end
            pp = carry_q;
            for (int unsigned t = 0; t < j; t++) begin
                pp = pp & sp[t];
            end
            sc[j] = term | pp;
        end
        ssum = sp ^ sc[K-1:0];
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        accept     = 1'b0;

        unique case (state_q)
            IDLE: begin
                accept = start;
            end
            RUN: begin
                for (int unsigned s = 0; s < NS; s++) begin
                    if (idx_q == IDX_W'(s)) begin
                        result_d[s*K +: K] = ssum;
                    end
                end
                carry_d = sc[K];
                if (last) begin
                    result_d[N] = sc[K];
                    overflow_d  = sc[K-1] ^ sc[K];
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                accept  = start;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d     = num1;
            b_d     = b_new;
            idx_d   = '0;
            carry_d = carry_new;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        busy     = (state_q == RUN);
        done     = (state_q == DONE);
        result   = result_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_multicycle_cla_adder.sv
// Directed bench for multicycle_cla_adder: N=8/K=4 and N=16/K=4 instances.
module tb_multicycle_cla_adder;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;

    logic        start8, sub8, busy8, done8, ov8;
    logic [7:0]  a8, b8;
    logic [8:0]  res8;

    logic        start16, sub16, busy16, done16, ov16;
    logic [15:0] a16, b16;
    logic [16:0] res16;

    always #5 clk = ~clk;

    multicycle_cla_adder #(.N(8), .K(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .num1(a8), .num2(b8), .sub(sub8),
        .busy(busy8), .done(done8), .result(res8), .overflow(ov8)
    );

    multicycle_cla_adder #(.N(16), .K(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .num1(a16), .num2(b16), .sub(sub16),
        .busy(busy16), .done(done16), .result(res16), .overflow(ov16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start an 8-bit op and check two RUN cycles, then the done cycle; ends in DONE with start low.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [8:0] er, input logic eo, input string tag);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; sub8 = s;
        @(negedge clk);
        start8 = 1'b0;
        chk({tag, "_busy0"}, 32'(busy8), 32'd1);
        chk({tag, "_done0"}, 32'(done8), 32'd0);
        @(negedge clk);
        chk({tag, "_busy1"}, 32'(busy8), 32'd1);
        chk({tag, "_done1"}, 32'(done8), 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done8), 32'd1);
        chk({tag, "_busyd"}, 32'(busy8), 32'd0);
        chk({tag, "_res"}, 32'(res8), 32'(er));
        chk({tag, "_ov"}, 32'(ov8), 32'(eo));
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_res8", 32'(res8), 32'd0);
        chk("rst_ov8", 32'(ov8), 32'd0);
        chk("rst_res16", 32'(res16), 32'd0);
        chk("rst_done16", 32'(done16), 32'd0);
        rst = 1'b0;

        op8(8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b0, "ff_ff");
        op8(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, "7f_01");
        op8(8'h00, 8'h00, 1'b0, 9'h000, 1'b0, "00_00");
`ifdef CLA_ADDER_SUB_EN
        op8(8'h0F, 8'hF0, 1'b1, 9'h01F, 1'b0, "sub_0f_f0");
        op8(8'h80, 8'h01, 1'b1, 9'h17F, 1'b1, "sub_80_01");
`else
        op8(8'h0F, 8'hF0, 1'b1, 9'h0FF, 1'b0, "nosub_0f_f0");
        op8(8'h80, 8'h01, 1'b1, 9'h081, 1'b0, "nosub_80_01");
`endif

        // DONE -> IDLE with start low; outputs hold.
        @(negedge clk);
        sub8 = 1'b0;
        chk("idle_done", 32'(done8), 32'd0);
        chk("idle_busy", 32'(busy8), 32'd0);
`ifdef CLA_ADDER_SUB_EN
        chk("hold_res", 32'(res8), 32'h17F);
        chk("hold_ov", 32'(ov8), 32'd1);
`else
        chk("hold_res", 32'(res8), 32'h081);
        chk("hold_ov", 32'(ov8), 32'd0);
`endif

        // Start re-asserted during RUN is ignored.
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        chk("ign_busy", 32'(busy8), 32'd1);
        @(negedge clk);
        chk("ign_done", 32'(done8), 32'd1);
        chk("ign_res", 32'(res8), 32'h046);
        chk("ign_ov", 32'(ov8), 32'd0);
        @(negedge clk);
        chk("ign_hold", 32'(res8), 32'h046);

        // Reset on the first RUN cycle aborts.
        start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_res", 32'(res8), 32'd0);
        chk("abort_ov", 32'(ov8), 32'd0);
        @(negedge clk);
        chk("abort_nodone1", 32'(done8), 32'd0);
        @(negedge clk);
        chk("abort_nodone2", 32'(done8), 32'd0);

        // Back-to-back on N=8: start held through DONE.
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80;
        chk("b2b_run", 32'(busy8), 32'd1);
        @(negedge clk);
        chk("b2b_done1", 32'(done8), 32'd1);
        chk("b2b_res1", 32'(res8), 32'h003);
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b_rerun", 32'(busy8), 32'd1);
        chk("b2b_nd0", 32'(done8), 32'd0);
        @(negedge clk);
        chk("b2b_nd1", 32'(done8), 32'd0);
        @(negedge clk);
        chk("b2b_done2", 32'(done8), 32'd1);
        chk("b2b_res2", 32'(res8), 32'h100);
        chk("b2b_ov2", 32'(ov8), 32'd1);

        // Back-to-back on N=16: four-cycle latency.
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001;
        @(negedge clk);
        a16 = 16'h7FFF; b16 = 16'h7FFF;
        for (int i = 0; i < 4; i++) begin
            chk("w16_busy_a", 32'(busy16), 32'd1);
            chk("w16_nd_a", 32'(done16), 32'd0);
            @(negedge clk);
        end
        chk("w16_done1", 32'(done16), 32'd1);
        chk("w16_res1", 32'(res16), 32'h10000);
        chk("w16_ov1", 32'(ov16), 32'd0);
        @(negedge clk);
        start16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("w16_busy_b", 32'(busy16), 32'd1);
            chk("w16_nd_b", 32'(done16), 32'd0);
            @(negedge clk);
        end
        chk("w16_done2", 32'(done16), 32'd1);
        chk("w16_res2", 32'(res16), 32'h0FFFE);
        chk("w16_ov2", 32'(ov16), 32'd1);
        @(negedge clk);
        chk("w16_idle", 32'(done16), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
